// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin arbiter for the common data bus.
// Picks at most one completed functional-unit result per cycle, starting the
// search at a rotating priority pointer, and registers the winner onto the
// CDB one cycle later. Requests carrying the all-ones "no tag" are granted
// so the FU drains, but are not broadcast.

`ifndef ROB_TAG_LEN
`define ROB_TAG_LEN 6
`endif

module cdb_arbiter #(
    parameter int NUM_FU = 4,
    parameter int TAG_W  = `ROB_TAG_LEN,
    parameter int DATA_W = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic [NUM_FU-1:0]          fu_valid,
    input  logic [NUM_FU*TAG_W-1:0]    fu_tag,
    input  logic [NUM_FU*DATA_W-1:0]   fu_data,
    output logic [NUM_FU-1:0]          fu_grant,
    output logic                       cdb_valid,
    output logic [TAG_W-1:0]           cdb_tag,
    output logic [DATA_W-1:0]          cdb_data,
    output logic [$clog2(NUM_FU)-1:0]  cdb_src
);

    localparam int               SRC_W    = $clog2(NUM_FU);
    localparam logic [TAG_W-1:0] NO_TAG   = '1;
    localparam logic [SRC_W:0]   NUM_FU_X = (SRC_W+1)'(NUM_FU);
    localparam logic [SRC_W-1:0] LAST_FU  = SRC_W'(NUM_FU - 1);

    logic [SRC_W-1:0]  ptr;
    logic [SRC_W-1:0]  ptr_next;
    logic [SRC_W-1:0]  win_idx;
    logic              win_found;
    logic [SRC_W:0]    scan_idx;
    logic [TAG_W-1:0]  tag_arr  [NUM_FU];
    logic [DATA_W-1:0] data_arr [NUM_FU];
    logic [TAG_W-1:0]  win_tag;
    logic [DATA_W-1:0] win_data;

    // Split the flat per-FU tag/data buses into indexable arrays.
    always_comb begin
        for (int i = 0; i < NUM_FU; i++) begin
            tag_arr[i]  = fu_tag[i*TAG_W +: TAG_W];
            data_arr[i] = fu_data[i*DATA_W +: DATA_W];
        end
    end

    // Scan from ptr upward with explicit wrap; first valid FU wins, nothing wins under reset/flush.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = '0;
        if (!reset && !flush) begin
            for (int k = 0; k < NUM_FU; k++) begin
                scan_idx = {1'b0, ptr} + (SRC_W+1)'(k);
                if (scan_idx >= NUM_FU_X) begin
                    scan_idx = scan_idx - NUM_FU_X;
                end
                if (!win_found && fu_valid[scan_idx[SRC_W-1:0]]) begin
                    win_found = 1'b1;
                    win_idx   = scan_idx[SRC_W-1:0];
                end
            end
        end
    end

    // Decode the one-hot grant, select the winner's payload and compute the pointer successor.
    always_comb begin
        fu_grant = '0;
        if (win_found) begin
            fu_grant[win_idx] = 1'b1;
        end
        win_tag  = tag_arr[win_idx];
        win_data = data_arr[win_idx];
        ptr_next = (win_idx == LAST_FU) ? '0 : win_idx + 1'b1;
    end

    // Priority pointer and CDB output register; flush squashes the next broadcast and rewinds ptr.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr       <= '0;
            cdb_valid <= 1'b0;
            cdb_tag   <= NO_TAG;
            cdb_data  <= '0;
            cdb_src   <= '0;
        end else if (flush) begin
            ptr       <= '0;
            cdb_valid <= 1'b0;
            cdb_tag   <= NO_TAG;
        end else if (win_found) begin
            ptr <= ptr_next;
            if (win_tag != NO_TAG) begin
                cdb_valid <= 1'b1;
                cdb_tag   <= win_tag;
                cdb_data  <= win_data;
                cdb_src   <= win_idx;
            end else begin
                cdb_valid <= 1'b0;
                cdb_tag   <= NO_TAG;
            end
        end else begin
            cdb_valid <= 1'b0;
            cdb_tag   <= NO_TAG;
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed scenarios followed by randomized traffic for
// cdb_arbiter, checked against a behavioural round-robin model.

module tb_cdb_arbiter;

    localparam int NUM_FU = 4;
    localparam int TAG_W  = 6;
    localparam int DATA_W = 32;
    localparam int SRC_W  = 2;
    localparam logic [TAG_W-1:0] NO_TAG = '1;

    logic                      clk = 1'b0;
    logic                      reset;
    logic                      flush;
    logic [NUM_FU-1:0]         fu_valid;
    logic [NUM_FU*TAG_W-1:0]   fu_tag;
    logic [NUM_FU*DATA_W-1:0]  fu_data;
    logic [NUM_FU-1:0]         fu_grant;
    logic                      cdb_valid;
    logic [TAG_W-1:0]          cdb_tag;
    logic [DATA_W-1:0]         cdb_data;
    logic [SRC_W-1:0]          cdb_src;

    cdb_arbiter #(
        .NUM_FU (NUM_FU),
        .TAG_W  (TAG_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .fu_valid  (fu_valid),
        .fu_tag    (fu_tag),
        .fu_data   (fu_data),
        .fu_grant  (fu_grant),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_data  (cdb_data),
        .cdb_src   (cdb_src)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    int compare_count = 0;
    int fail_count    = 0;

    logic              fu_v [NUM_FU];
    logic [TAG_W-1:0]  fu_t [NUM_FU];
    logic [DATA_W-1:0] fu_d [NUM_FU];
    int                refill_mode;
    int                wait_cycles [NUM_FU];
    logic [NUM_FU-1:0] seen_grant;

    int                m_ptr;
    logic              m_valid;
    logic [TAG_W-1:0]  m_tag;
    logic [DATA_W-1:0] m_data;
    int                m_src;

    task automatic checkOutput(input string name, input logic [63:0] obs, input logic [63:0] exp);
        compare_count++;
        assert (obs === exp) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic applyStimulus();
        for (int i = 0; i < NUM_FU; i++) begin
            fu_valid[i]                   = fu_v[i];
            fu_tag[i*TAG_W +: TAG_W]      = fu_t[i];
            fu_data[i*DATA_W +: DATA_W]   = fu_d[i];
        end
    endtask

    function automatic logic [TAG_W-1:0] good_tag();
        return TAG_W'($urandom_range(0, (1 << TAG_W) - 2));
    endfunction

    function automatic void model_reset();
        m_ptr   = 0;
        m_valid = 1'b0;
        m_tag   = NO_TAG;
        m_data  = '0;
        m_src   = 0;
        for (int i = 0; i < NUM_FU; i++) wait_cycles[i] = 0;
    endfunction

    // Round-robin rule: first requesting FU at or after the pointer, modulo NUM_FU.
    function automatic int model_winner();
        if (flush || reset) return -1;
        for (int k = 0; k < NUM_FU; k++) begin
            if (fu_v[(m_ptr + k) % NUM_FU]) return (m_ptr + k) % NUM_FU;
        end
        return -1;
    endfunction

    task automatic check_bus(input string name);
        checkOutput({name, "/cdb_valid"}, 64'(cdb_valid), 64'(m_valid));
        checkOutput({name, "/cdb_tag"},   64'(cdb_tag),   64'(m_tag));
        checkOutput({name, "/cdb_data"},  64'(cdb_data),  64'(m_data));
        checkOutput({name, "/cdb_src"},   64'(cdb_src),   64'(m_src));
    endtask

    // One clock cycle: drive, check grant mid-cycle, clock, update model and FUs, check bus.
    task automatic run_cycle(input string name);
        int w;
        logic [NUM_FU-1:0] exp_grant;
        applyStimulus();
        #1;
        w = model_winner();
        exp_grant = '0;
        if (w >= 0) exp_grant[w] = 1'b1;
        seen_grant = fu_grant;
        checkOutput({name, "/grant"}, 64'(fu_grant), 64'(exp_grant));
        for (int i = 0; i < NUM_FU; i++) begin
            if (flush || !fu_v[i] || i == w) begin
                wait_cycles[i] = 0;
            end else begin
                wait_cycles[i]++;
                checkOutput({name, "/fair_wait"}, 64'(wait_cycles[i] < NUM_FU), 64'd1);
            end
        end
        @(posedge clk);
        if (flush) begin
            m_ptr   = 0;
            m_valid = 1'b0;
            m_tag   = NO_TAG;
        end else if (w >= 0) begin
            m_ptr = (w + 1) % NUM_FU;
            if (fu_t[w] != NO_TAG) begin
                m_valid = 1'b1;
                m_tag   = fu_t[w];
                m_data  = fu_d[w];
                m_src   = w;
            end else begin
                m_valid = 1'b0;
                m_tag   = NO_TAG;
            end
        end else begin
            m_valid = 1'b0;
            m_tag   = NO_TAG;
        end
        if (w >= 0) begin
            if (refill_mode == 0) begin
                fu_v[w] = 1'b0;
            end else if (refill_mode == 1) begin
                fu_t[w] = good_tag();
                fu_d[w] = $urandom;
            end else begin
                fu_v[w] = 1'($urandom_range(0, 1));
                fu_t[w] = ($urandom_range(0, 7) == 0) ? NO_TAG : good_tag();
                fu_d[w] = $urandom;
            end
        end
        #1;
        check_bus(name);
    endtask

    initial begin
        $display("[TB] cdb_arbiter bench start");
        reset       = 1'b1;
        flush       = 1'b0;
        refill_mode = 0;
        seen_grant  = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            fu_v[i] = 1'b1;
            fu_t[i] = TAG_W'(i + 1);
            fu_d[i] = 32'hA000_0000 + 32'(i);
        end
        model_reset();
        applyStimulus();
        #3;
        checkOutput("reset/grant", 64'(fu_grant), 64'd0);
        check_bus("reset");
        @(posedge clk);
        #2;
        checkOutput("reset_edge/grant", 64'(fu_grant), 64'd0);
        check_bus("reset_edge");

        // Idle after reset release.
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < NUM_FU; i++) fu_v[i] = 1'b0;
        for (int c = 0; c < 5; c++) begin
            run_cycle("idle");
            checkOutput("idle/cdb_tag_const", 64'(cdb_tag), 64'(NO_TAG));
        end

        // All four request once; grants rotate 0..3, tags 1..4 follow one cycle later.
        for (int i = 0; i < NUM_FU; i++) begin
            fu_v[i] = 1'b1;
            fu_t[i] = TAG_W'(i + 1);
            fu_d[i] = $urandom;
        end
        refill_mode = 0;
        for (int s = 0; s < NUM_FU; s++) begin
            run_cycle("sweep");
            checkOutput("sweep/grant_seq", 64'(seen_grant), 64'(1) << s);
            checkOutput("sweep/tag_seq",   64'(cdb_tag),    64'(s + 1));
        end
        run_cycle("sweep_drain");
        checkOutput("sweep_drain/valid", 64'(cdb_valid), 64'd0);

        // FU0 and FU2 always busy: grants alternate.
        refill_mode = 1;
        fu_v[0] = 1'b1; fu_t[0] = good_tag(); fu_d[0] = $urandom;
        fu_v[2] = 1'b1; fu_t[2] = good_tag(); fu_d[2] = $urandom;
        for (int s = 0; s < 8; s++) begin
            run_cycle("alternate");
            checkOutput("alternate/grant_seq", 64'(seen_grant), (s % 2 == 0) ? 64'h1 : 64'h4);
        end

        // Flush to rewind ptr, then steer it to 3 and check the wrap from FU3 to FU0.
        flush = 1'b1;
        run_cycle("flush_rewind");
        flush = 1'b0;
        refill_mode = 0;
        fu_v[0] = 1'b0;
        fu_v[2] = 1'b1;
        run_cycle("wrap_setup");
        checkOutput("wrap_setup/grant", 64'(seen_grant), 64'h4);
        fu_v[0] = 1'b1; fu_t[0] = 6'd10; fu_d[0] = $urandom;
        fu_v[3] = 1'b1; fu_t[3] = 6'd13; fu_d[3] = $urandom;
        run_cycle("wrap_fu3");
        checkOutput("wrap_fu3/grant", 64'(seen_grant), 64'h8);
        run_cycle("wrap_fu0");
        checkOutput("wrap_fu0/grant", 64'(seen_grant), 64'h1);
        checkOutput("wrap_fu0/tag", 64'(cdb_tag), 64'd10);
        fu_v[1] = 1'b1; fu_t[1] = 6'd21; fu_d[1] = $urandom;
        fu_v[2] = 1'b1; fu_t[2] = 6'd22; fu_d[2] = $urandom;
        run_cycle("wrap_ptr1");
        checkOutput("wrap_ptr1/grant", 64'(seen_grant), 64'h2);
        run_cycle("wrap_tail");

        // Invalid-tag request drains but does not broadcast; ptr moves past it.
        fu_v[1] = 1'b1; fu_t[1] = NO_TAG; fu_d[1] = $urandom;
        run_cycle("notag");
        checkOutput("notag/grant", 64'(seen_grant), 64'h2);
        checkOutput("notag/valid", 64'(cdb_valid), 64'd0);
        checkOutput("notag/tag",   64'(cdb_tag),   64'(NO_TAG));
        fu_v[1] = 1'b1; fu_t[1] = 6'd31; fu_d[1] = $urandom;
        fu_v[2] = 1'b1; fu_t[2] = 6'd32; fu_d[2] = $urandom;
        run_cycle("notag_ptr2");
        checkOutput("notag_ptr2/grant", 64'(seen_grant), 64'h4);
        run_cycle("notag_tail");

        // Flush with everyone requesting.
        for (int i = 0; i < NUM_FU; i++) begin
            fu_v[i] = 1'b1;
            fu_t[i] = TAG_W'(i + 1);
            fu_d[i] = $urandom;
        end
        flush = 1'b1;
        run_cycle("flush_all");
        checkOutput("flush_all/grant", 64'(seen_grant), 64'd0);
        checkOutput("flush_all/valid", 64'(cdb_valid), 64'd0);
        flush = 1'b0;
        run_cycle("post_flush");
        checkOutput("post_flush/grant", 64'(seen_grant), 64'h1);
        checkOutput("post_flush/valid", 64'(cdb_valid), 64'd1);

        // Asynchronous reset while a broadcast is on the bus.
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        checkOutput("async_reset/valid", 64'(cdb_valid), 64'd0);
        checkOutput("async_reset/grant", 64'(fu_grant),  64'd0);
        check_bus("async_reset");
        @(negedge clk);
        reset = 1'b0;

        // Randomized traffic with occasional flushes and invalid tags.
        refill_mode = 2;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (!fu_v[i] && $urandom_range(0, 2) == 0) begin
                    fu_v[i] = 1'b1;
                    fu_t[i] = ($urandom_range(0, 7) == 0) ? NO_TAG : good_tag();
                    fu_d[i] = $urandom;
                end
            end
            flush = ($urandom_range(0, 19) == 0);
            run_cycle("random");
        end
        flush = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, fail_count);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the single common data bus (CDB) between NUM_FU functional-unit result ports.
- Uses round-robin arbitration, one broadcast per cycle.
- Registers the winning result and drives the CDB broadcast. cdb_valid/cdb_tag feed the map table's ready_flag/rob_tag_from_cdb, and the reservation stations and ROB.

Parameters:
- NUM_FU, 4, number of requesting functional units (2..8).
- TAG_W, `ROB_TAG_LEN, ROB tag width; all-ones tag means "no tag".
- DATA_W, 32, result data width.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous squash (branch mispredict); kills the current cycle's arbitration and the output register.
- fu_valid  in  NUM_FU  bit i: FU i holds a completed result.
- fu_tag  in  NUM_FU*TAG_W  FU i tag at [i*TAG_W +: TAG_W].
- fu_data  in  NUM_FU*DATA_W  FU i data at [i*DATA_W +: DATA_W].
- fu_grant  out  NUM_FU  one-hot or zero, combinational; FU i's result is accepted this cycle.
- cdb_valid  out  1  registered broadcast valid.
- cdb_tag  out  TAG_W  registered broadcast ROB tag.
- cdb_data  out  DATA_W  registered broadcast data.
- cdb_src  out  $clog2(NUM_FU)  registered index of the broadcasting FU (debug/perf).

Behaviour:
- Reset (async, immediate): cdb_valid=0, cdb_tag=all-ones, cdb_data=0, cdb_src=0, priority pointer ptr=0.
  - fu_grant is 0 while reset is high.
- Handshake:
  - FU i holds fu_valid/tag/data stable until the cycle fu_grant[i]=1.
  - The result is consumed at that clock edge. The FU may present a new result the following cycle.
  - There is no CDB backpressure.
- Arbitration (combinational, each cycle flush=0):
  - Scan FU indices ptr, ptr+1, ..., wrapping modulo NUM_FU.
  - The first i with fu_valid[i]=1 gets fu_grant[i]=1.
  - At most one grant per cycle. With no valid requests, fu_grant=0.
- Pointer update:
  - On a grant to i, ptr <= (i+1) mod NUM_FU.
  - With no grant, ptr holds.
  - Guarantee: a continuously valid FU is granted within NUM_FU cycles.
- Output register, latency 1:
  - A grant at edge N gives cdb_valid=1, cdb_tag=fu_tag[i], cdb_data=fu_data[i], cdb_src=i during cycle N+1.
  - A cycle with no grant gives cdb_valid=0 and cdb_tag=all-ones next cycle; cdb_data and cdb_src hold.
- Invalid-tag requests:
  - fu_valid=1 with an all-ones tag is granted normally (so the FU drains) and advances ptr.
  - It is not broadcast: cdb_valid=0, cdb_tag=all-ones next cycle.
- Flush:
  - flush=1 forces fu_grant=0 that cycle.
  - Next cycle cdb_valid=0 and cdb_tag=all-ones.
  - ptr <= 0.
  - A broadcast already on the bus during the flush cycle is not retracted.
- Single requester: the same FU is granted every cycle it is valid (back-to-back broadcasts).
- NUM_FU not a power of two: the pointer wrap is explicit (ptr==NUM_FU-1 goes to 0). ptr never holds an out-of-range value.
- Reset asserted mid-broadcast: outputs clear immediately, without waiting for a clock edge.

Test Plan:
- Reset release, NUM_FU=4, all fu_valid=0 -> fu_grant=0000, cdb_valid=0, cdb_tag=all-ones for 5 cycles.
- fu_valid=1111 held with FU i tag = i+1, each FU dropping valid after its grant:
  - Grants go 0001, 0010, 0100, 1000.
  - cdb_tag shows 1, 2, 3, 4 on the next four cycles, each one cycle after its grant.
- Round-robin fairness: FU0 and FU2 permanently valid (new result every cycle), ptr=0 -> grants alternate FU0, FU2, FU0, FU2. No FU waits more than 4 cycles.
- Wrap-around: ptr=3 (after a grant to FU2), fu_valid=1001 -> FU3 granted, then FU0; ptr returns to 1.
- Invalid tag: FU1 valid with tag all-ones, alone -> fu_grant=0010; next cycle cdb_valid=0, cdb_tag=all-ones; ptr=2.
- Flush and reset:
  - flush=1 while fu_valid=1111 -> fu_grant=0000 that cycle; next cycle cdb_valid=0; the following grant goes to FU0.
  - Async reset pulse between clock edges while cdb_valid=1 -> cdb_valid falls immediately.
